fp_mult_prep_pipe: RTL and testbench
====================================

Name: fp_mult_prep_pipe

Overview:
Parametrised, pipelined successor to the FP multiplier input-preparation stage. It accepts operand pairs (a, b) in any 1-sign/EXP_W-exponent/MAN_W-mantissa format through a valid/ready handshake. For each pair it classifies both operands (NaN, Inf, zero, subnormal), unpacks the fields with the hidden bit restored and the subnormal exponent fixed up, and presents the result through a 2-entry skid buffer to the multiplier datapath. It also keeps a saturating count of exception-flagged pairs for debug.

Parameters:
EXP_W, 3, exponent width in bits
MAN_W, 4, stored mantissa width in bits (excluding hidden bit)
CNT_W, 8, width of the exception counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept a pair this cycle
a  in  1+EXP_W+MAN_W  operand A, format {sign, exp, man}
b  in  1+EXP_W+MAN_W  operand B
out_valid  out  1  prepared pair valid
out_ready  in  1  downstream accepts the prepared pair
Sa  out  1  A sign
Sb  out  1  B sign
Sp  out  1  product sign, Sa^Sb
Ea  out  EXP_W  A effective exponent
Eb  out  EXP_W  B effective exponent
Ma  out  MAN_W+1  A mantissa with hidden bit, {hidden, man}
Mb  out  MAN_W+1  B mantissa with hidden bit
InputExc  out  5  {any, ANaN, BNaN, AInf, BInf}
Zero  out  2  {AZero, BZero}
Sub  out  2  {ASub, BSub}
exc_clr  in  1  synchronous clear of exc_count
exc_count  out  CNT_W  saturating count of accepted pairs with InputExc[4]=1

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. Reset dominates every other input, including exc_clr.
- Reset values: out_valid=0. All data outputs (Sa, Sb, Sp, Ea, Eb, Ma, Mb, InputExc, Zero, Sub) are 0. exc_count=0. Both skid entries are empty. in_ready=0 while rst is high and 1 in the first cycle after rst deasserts.
- Classification, per operand X (combinational on the input side, then registered):
  - expAll1 = &exp; expAll0 = ~|exp; manNZ = |man.
  - XNaN = expAll1 & manNZ; XInf = expAll1 & ~manNZ.
  - XZero = expAll0 & ~manNZ; XSub = expAll0 & manNZ.
  - Hidden bit = ~expAll0.
  - Effective exponent = 1 when expAll0, otherwise the raw exponent. Zero therefore reports Ea=1 and Ma=0.
  - InputExc[4] = ANaN|BNaN|AInf|BInf. Zero and subnormal operands do not set it.
- Handshake:
  - An input transfer happens when in_valid & in_ready. An output transfer happens when out_valid & out_ready.
  - Latency is 1 cycle: a pair accepted at edge N is visible on the outputs after edge N when the buffer was empty.
- Buffering: 2-entry FIFO with a main/output register and a skid register.
  - in_ready = ~skid_full, registered; it has no combinational path from out_ready.
  - Outputs are driven only from the main register.
  - Accept while main is empty, or while main drains the same cycle: the pair loads into main.
  - Accept while main is held (out_valid & ~out_ready): the pair loads into skid, and in_ready drops the next cycle.
  - When main drains and skid is full: skid moves into main, and in_ready rises the next cycle.
  - Simultaneous accept and drain with skid full cannot occur, because in_ready=0 in that case.
  - Order is strictly FIFO. There is no drop or duplication.
  - Output data stays stable while out_valid & ~out_ready.
- Counter:
  - exc_count increments by 1 on each input transfer with InputExc[4]=1.
  - It saturates at 2^CNT_W-1.
  - exc_clr forces it to 0. If exc_clr and a counted transfer occur in the same cycle, the result is 0; clear wins.
- Reset mid-operation: both entries are discarded and the counter is cleared. No out_valid is produced for pairs accepted before the reset.
- Widths: all field extraction is by parameter. There are no hard-coded bit indices outside the default parameters.

Test Plan:
1. Defaults, a=0x3A, b=0xC0, out_ready=1 -> one cycle later: out_valid=1, Sa=0, Sb=1, Sp=1, Ea=3, Eb=4, Ma=5'b11010, Mb=5'b10000, InputExc=0, Zero=0, Sub=0.
2. a=0x75, b=0x70 -> InputExc=5'b11001 (any, ANaN, BInf), Ma=5'b10101, Mb=5'b10000, exc_count increments to 1.
3. a=0x05, b=0x80 -> Sub=2'b10, Zero=2'b01, Ea=1, Ma=5'b00101, Eb=1, Mb=0, Sp=1, InputExc=0, exc_count unchanged.
4. Backpressure: hold out_ready=0 and offer pairs P0, P1, P2 back-to-back -> P0 and P1 accepted, in_ready=0 from the cycle after P1, P2 held. Raise out_ready -> outputs P0, P1, P2 in order, with outputs stable while stalled.
5. Counter: use CNT_W=2 and send 5 Inf pairs -> exc_count=3 (saturated). Then assert exc_clr together with a 6th Inf transfer -> exc_count=0.
6. Reset with both entries full -> next cycle out_valid=0, in_ready=1, exc_count=0. Repeat test 1 with EXP_W=5, MAN_W=10 (half precision), a=16'h3C00 -> Ea=15, Ma=11'h400.

Source files
------------

// File: rtl/fp_mult_prep_pipe.sv
// FP multiplier input preparation: classifies and unpacks an operand pair, then
// hands it to the multiplier through a 2-entry skid buffer. Counts exception pairs.
module fp_mult_prep_pipe #(
  parameter int unsigned EXP_W = 3,
  parameter int unsigned MAN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   Sa,
  output logic                   Sb,
  output logic                   Sp,
  output logic [EXP_W-1:0]       Ea,
  output logic [EXP_W-1:0]       Eb,
  output logic [MAN_W:0]         Ma,
  output logic [MAN_W:0]         Mb,
  output logic [4:0]             InputExc,
  output logic [1:0]             Zero,
  output logic [1:0]             Sub,
  input  logic                   exc_clr,
  output logic [CNT_W-1:0]       exc_count
);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] e;
    logic [MAN_W:0]   m;
    logic             nan;
    logic             inf;
    logic             zero;
    logic             sub;
  } op_t;

  typedef struct packed {
    logic             sa;
    logic             sb;
    logic             sp;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W:0]   ma;
    logic [MAN_W:0]   mb;
    logic [4:0]       exc;
    logic [1:0]       zero;
    logic [1:0]       sub;
  } prep_t;

  function automatic op_t classify(input logic [EXP_W+MAN_W:0] x);
    op_t              r;
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             all1, all0, nz;
    exp_f  = x[MAN_W +: EXP_W];
    man_f  = x[MAN_W-1:0];
    all1   = &exp_f;
    all0   = ~|exp_f;
    nz     = |man_f;
    r.sign = x[EXP_W+MAN_W];
    // Subnormals and zero use exponent 1 with the hidden bit cleared.
    r.e    = all0 ? EXP_W'(1) : exp_f;
    r.m    = {~all0, man_f};
    r.nan  = all1 & nz;
    r.inf  = all1 & ~nz;
    r.zero = all0 & ~nz;
    r.sub  = all0 & nz;
    return r;
  endfunction

  op_t   op_a, op_b;
  prep_t in_prep;

  always_comb begin
    op_a            = classify(a);
    op_b            = classify(b);
    in_prep.sa      = op_a.sign;
    in_prep.sb      = op_b.sign;
    in_prep.sp      = op_a.sign ^ op_b.sign;
    in_prep.ea      = op_a.e;
    in_prep.eb      = op_b.e;
    in_prep.ma      = op_a.m;
    in_prep.mb      = op_b.m;
    in_prep.exc     = {op_a.nan | op_b.nan | op_a.inf | op_b.inf,
                       op_a.nan, op_b.nan, op_a.inf, op_b.inf};
    in_prep.zero    = {op_a.zero, op_b.zero};
    in_prep.sub     = {op_a.sub, op_b.sub};
  end

  prep_t            main_q, main_d, skid_q, skid_d;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire, out_fire;

  assign in_ready  = rdy_q & ~rst;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v_q & out_ready;

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (out_fire || !main_v_q) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (in_fire) begin
        main_d   = in_prep;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d   = in_prep;
      skid_v_d = 1'b1;
    end
    rdy_d = ~skid_v_d;

    cnt_d = cnt_q;
    if (exc_clr) begin
      cnt_d = '0;
    end else if (in_fire && in_prep.exc[4] && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      // Held high so in_ready rises as soon as rst drops.
      rdy_q    <= 1'b1;
      cnt_q    <= '0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = main_v_q;
  assign Sa        = main_q.sa;
  assign Sb        = main_q.sb;
  assign Sp        = main_q.sp;
  assign Ea        = main_q.ea;
  assign Eb        = main_q.eb;
  assign Ma        = main_q.ma;
  assign Mb        = main_q.mb;
  assign InputExc  = main_q.exc;
  assign Zero      = main_q.zero;
  assign Sub       = main_q.sub;
  assign exc_count = cnt_q;

endmodule

// File: tb/tb_fp_mult_prep_pipe.sv
// Bench for fp_mult_prep_pipe: directed steps plus random traffic against an
// arithmetic reference model and an in-order queue of pending pairs.
module tb_fp_mult_prep_pipe;

  localparam int EW = 3;
  localparam int MW = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter DUT
  logic       in_valid, in_ready, out_valid, out_ready, exc_clr;
  logic [7:0] a, b;
  logic       Sa, Sb, Sp;
  logic [2:0] Ea, Eb;
  logic [4:0] Ma, Mb, InputExc;
  logic [1:0] Zero, Sub;
  logic [7:0] exc_count;

  // Half-precision DUT with a 2-bit counter
  logic        in_valid1, in_ready1, out_valid1, out_ready1, exc_clr1;
  logic [15:0] a1, b1;
  logic        Sa1, Sb1, Sp1;
  logic [4:0]  Ea1, Eb1, InputExc1;
  logic [10:0] Ma1, Mb1;
  logic [1:0]  Zero1, Sub1, exc_count1;

  fp_mult_prep_pipe u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .Sa(Sa), .Sb(Sb), .Sp(Sp),
    .Ea(Ea), .Eb(Eb), .Ma(Ma), .Mb(Mb), .InputExc(InputExc), .Zero(Zero), .Sub(Sub),
    .exc_clr(exc_clr), .exc_count(exc_count)
  );

  fp_mult_prep_pipe #(.EXP_W(5), .MAN_W(10), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .Sa(Sa1), .Sb(Sb1), .Sp(Sp1),
    .Ea(Ea1), .Eb(Eb1), .Ma(Ma1), .Mb(Mb1), .InputExc(InputExc1), .Zero(Zero1),
    .Sub(Sub1), .exc_clr(exc_clr1), .exc_count(exc_count1)
  );

  typedef struct {
    int unsigned s, e, m;
    bit          nan, inf, zero, sub;
  } op_t;

  typedef struct {
    logic [31:0] sa, sb, sp, ea, eb, ma, mb, exc, zero, sub;
  } exp_t;

  int n_pass = 0;
  int n_chk  = 0;

  exp_t q[$];
  int   cnt_m;

  function automatic op_t cls(int unsigned x, int ew, int mw);
    op_t         r;
    int unsigned man, ex, emax;
    man    = x % (1 << mw);
    ex     = (x >> mw) % (1 << ew);
    emax   = (1 << ew) - 1;
    r.s    = (x >> (ew + mw)) & 1;
    r.nan  = (ex == emax) && (man != 0);
    r.inf  = (ex == emax) && (man == 0);
    r.zero = (ex == 0) && (man == 0);
    r.sub  = (ex == 0) && (man != 0);
    r.e    = (ex == 0) ? 1 : ex;
    r.m    = (ex == 0) ? man : man + (1 << mw);
    return r;
  endfunction

  function automatic exp_t model(int unsigned xa, int unsigned xb, int ew, int mw);
    exp_t r;
    op_t  pa, pb;
    int   any;
    pa     = cls(xa, ew, mw);
    pb     = cls(xb, ew, mw);
    any    = (pa.nan || pb.nan || pa.inf || pb.inf) ? 1 : 0;
    r.sa   = pa.s;
    r.sb   = pb.s;
    r.sp   = (pa.s != pb.s) ? 1 : 0;
    r.ea   = pa.e;
    r.eb   = pb.e;
    r.ma   = pa.m;
    r.mb   = pb.m;
    r.exc  = any * 16 + pa.nan * 8 + pb.nan * 4 + pa.inf * 2 + pb.inf;
    r.zero = pa.zero * 2 + pb.zero;
    r.sub  = pa.sub * 2 + pb.sub;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Apply the currently driven inputs to the model, then advance to the next negedge.
  task automatic tick0();
    bit   ifire, ofire;
    exp_t n;
    if (rst) begin
      q.delete();
      cnt_m = 0;
    end else begin
      ifire = in_valid && (q.size() < 2);
      ofire = (q.size() > 0) && out_ready;
      n     = model(a, b, EW, MW);
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(n);
      if (exc_clr) cnt_m = 0;
      else if (ifire && n.exc[4] && cnt_m < (1 << CW) - 1) cnt_m++;
    end
    @(negedge clk);
  endtask

  task automatic check0(input string tag);
    chk({tag, "_ovalid"}, out_valid, (q.size() > 0) ? 1 : 0);
    chk({tag, "_iready"}, in_ready, (!rst && q.size() < 2) ? 1 : 0);
    chk({tag, "_cnt"}, exc_count, cnt_m);
    if (q.size() > 0) begin
      chk({tag, "_Sa"}, Sa, q[0].sa);
      chk({tag, "_Sb"}, Sb, q[0].sb);
      chk({tag, "_Sp"}, Sp, q[0].sp);
      chk({tag, "_Ea"}, Ea, q[0].ea);
      chk({tag, "_Eb"}, Eb, q[0].eb);
      chk({tag, "_Ma"}, Ma, q[0].ma);
      chk({tag, "_Mb"}, Mb, q[0].mb);
      chk({tag, "_Exc"}, InputExc, q[0].exc);
      chk({tag, "_Zero"}, Zero, q[0].zero);
      chk({tag, "_Sub"}, Sub, q[0].sub);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ovalid"}, out_valid, 0);
    chk({tag, "_iready"}, in_ready, 1);
    chk({tag, "_cnt"}, exc_count, 0);
    chk({tag, "_data"}, {Sa, Sb, Sp, Ea, Eb, Ma, Mb, InputExc, Zero, Sub}, 0);
  endtask

  exp_t m1;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; exc_clr = 1'b0; a = '0; b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; exc_clr1 = 1'b0; a1 = '0; b1 = '0;
    q.delete(); cnt_m = 0;
    @(negedge clk);
    tick0();
    tick0();
    chk("rst_iready_low", in_ready, 0);
    rst = 1'b0;
    #1;
    check_reset_outs("rst0");

    // Test 1: normal operands
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h3A; b = 8'hC0;
    tick0();
    check0("t1");
    chk("t1_Ea_const", Ea, 3);
    chk("t1_Ma_const", Ma, 5'b11010);
    chk("t1_Mb_const", Mb, 5'b10000);
    chk("t1_Sp_const", Sp, 1);

    // Test 2: NaN x Inf
    a = 8'h75; b = 8'h70;
    tick0();
    check0("t2");
    chk("t2_Exc_const", InputExc, 5'b11001);
    chk("t2_cnt_const", exc_count, 1);

    // Test 3: subnormal x negative zero
    a = 8'h05; b = 8'h80;
    tick0();
    check0("t3");
    chk("t3_SubZero_const", {Sub, Zero}, 4'b1001);
    chk("t3_EaMa_const", {Ea, Ma}, {3'd1, 5'b00101});
    chk("t3_EbMb_const", {Eb, Mb}, {3'd1, 5'b00000});
    chk("t3_cnt_const", exc_count, 1);
    in_valid = 1'b0;
    tick0();
    check0("t3_drain");

    // Test 4: backpressure, P0/P1 buffered, P2 held off
    out_ready = 1'b0; in_valid = 1'b1; b = 8'h3A;
    a = 8'h11; tick0(); check0("t4_p0");
    a = 8'h22; tick0(); check0("t4_p1");
    chk("t4_full_iready", in_ready, 0);
    a = 8'h33; tick0(); check0("t4_stall1");
    tick0(); check0("t4_stall2");
    chk("t4_stable_Ma", Ma, 5'b10001);
    out_ready = 1'b1;
    tick0(); check0("t4_out1");
    chk("t4_out1_Ma", Ma, 5'b10010);
    tick0(); check0("t4_out2");
    chk("t4_out2_Ma", Ma, 5'b10011);
    in_valid = 1'b0;
    tick0(); check0("t4_empty");

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      exc_clr   = ($urandom_range(0, 31) == 0);
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a[6:4] = 3'b111;
      if ($urandom_range(0, 3) == 0) b[6:4] = 3'b000;
      tick0();
      check0("rnd");
    end
    exc_clr = 1'b0;

    // Test 6: reset with both entries full
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h78; b = 8'h12;
    tick0(); tick0(); tick0();
    check0("t6_fill");
    chk("t6_full", in_ready, 0);
    rst = 1'b1; in_valid = 1'b0;
    tick0();
    chk("t6_rst_iready", in_ready, 0);
    rst = 1'b0;
    #1;
    check_reset_outs("t6");

    // Test 5: saturating counter on the half-precision DUT
    in_valid1 = 1'b1; a1 = 16'h3C00; b1 = 16'h7C00;
    m1 = model(a1, b1, 5, 10);
    tick0(); tick0();
    chk("t5_cnt2", exc_count1, 2);
    tick0(); tick0(); tick0();
    chk("t5_cnt_sat", exc_count1, 3);
    chk("t5_Ea", Ea1, m1.ea);
    chk("t5_Ea_const", Ea1, 15);
    chk("t5_Ma", Ma1, m1.ma);
    chk("t5_Ma_const", Ma1, 11'h400);
    chk("t5_Eb", Eb1, m1.eb);
    chk("t5_Exc", InputExc1, m1.exc);
    chk("t5_ovalid", out_valid1, 1);
    exc_clr1 = 1'b1;
    tick0();
    chk("t5_clr_wins", exc_count1, 0);
    exc_clr1 = 1'b0; in_valid1 = 1'b0;
    tick0();
    chk("t5_idle", out_valid1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
